rv_core_sequencer: RTL and testbench

Multi-cycle control FSM that sequences the RV32I minimal ALU datapath: fetch, decode-to-unit-select, execute, writeback/PC-update.
- Owns the architectural PC.
- Drives the instruction-memory handshake.
- Issues one-hot enables to the ALU sub-units (register-register, register-immediate, branch, jal, jalr, lui, auipc).
- Gates register-file writes.
- Sits between instruction memory, the ALU wrapper and the register file.

---
 rtl/rv_core_sequencer.sv | 251 +++++++++++++++++++++++++
 tb/tb_rv_core_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_core_sequencer.sv
// ----------------------------------------------------------------------------
// rv_core_sequencer
//
// Multi-cycle control FSM for the RV32I minimal ALU datapath. It owns the
// architectural PC, runs the instruction-memory handshake, issues a one-hot
// enable pulse to the selected ALU sub-unit, gates register-file writes and
// counts retired instructions. An illegal opcode or a misaligned redirect
// target parks the core in TRAP until reset.
//
// Parameters
//   RESET_PC      PC value loaded on reset
//   EXEC_LATENCY  clocks from unit_enable pulse to a valid ALU result (1-7)
//
// Ports
//   clock, reset_n          rising-edge clock, async active-low reset
//   imem_req/addr           fetch request (held until imem_ready), address = pc
//   imem_ready/rdata        fetch completes this cycle with this word
//   instruction, pc         latched instruction word and architectural PC
//   unit_enable[6:0]        one-hot: rr, ri, branch, jal, jalr, lui, auipc
//   alu_rd, alu_rd_value    destination register and result from the ALU
//   alu_next_pc_valid/pc    redirect target from the ALU
//   rf_write_*              register-file write strobe, address, data
//   illegal_instruction     sticky trap cause
//   halted                  high while in TRAP
//   retired_count           retired-instruction counter (wraps)
//
// State table
//   state        | meaning
//   ST_FETCH     | request imem at pc, wait for imem_ready
//   ST_DECODE    | map opcode to a unit, or trap on an illegal opcode
//   ST_EXECUTE   | one-cycle unit_enable pulse
//   ST_WAIT      | down-count EXEC_LATENCY cycles; sample ALU on terminal count
//   ST_WRITEBACK | register write strobe, PC update, retire
//   ST_TRAP      | halted, no requests or strobes until reset
// ----------------------------------------------------------------------------
module rv_core_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned EXEC_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [6:0]  unit_enable,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_rd_value,
    input  logic        alu_next_pc_valid,
    input  logic [31:0] alu_next_pc,
    output logic        rf_write_enable,
    output logic [4:0]  rf_write_addr,
    output logic [31:0] rf_write_data,
    output logic        illegal_instruction,
    output logic        halted,
    output logic [31:0] retired_count
);

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_WAIT      = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } state_t;

    localparam int U_RR     = 0;
    localparam int U_RI     = 1;
    localparam int U_BRANCH = 2;
    localparam int U_JAL    = 3;
    localparam int U_JALR   = 4;
    localparam int U_LUI    = 5;
    localparam int U_AUIPC  = 6;

    localparam logic [2:0] WAIT_LOAD = 3'(EXEC_LATENCY);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [6:0]  unit_sel_q, unit_sel_d;
    logic [6:0]  unit_en_q, unit_en_d;
    logic [2:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] next_pc_q, next_pc_d;
    logic        misalign_q, misalign_d;
    logic        imem_req_q, imem_req_d;
    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_addr_q, rf_addr_d;
    logic [31:0] rf_data_q, rf_data_d;
    logic        illegal_q, illegal_d;
    logic        halted_q, halted_d;
    logic [31:0] retired_q, retired_d;

    logic [6:0]  dec_sel;
    logic [2:0]  wait_dec;
    logic        is_ctrl;
    logic        redirect;

    // Returns zero for anything that is not one of the seven supported opcodes.
    function automatic logic [6:0] decode_unit(input logic [31:0] instr);
        logic [6:0] sel;
        sel = '0;
        if (instr[1:0] == 2'b11) begin
            case (instr[6:0])
                7'b0110011: sel[U_RR]     = 1'b1;
                7'b0010011: sel[U_RI]     = 1'b1;
                7'b1100011: sel[U_BRANCH] = 1'b1;
                7'b1101111: sel[U_JAL]    = 1'b1;
                7'b1100111: sel[U_JALR]   = 1'b1;
                7'b0110111: sel[U_LUI]    = 1'b1;
                7'b0010111: sel[U_AUIPC]  = 1'b1;
                default:    sel           = '0;
            endcase
        end
        return sel;
    endfunction

    assign dec_sel  = decode_unit(instr_q);
    assign wait_dec = wait_cnt_q - 3'd1;
    assign is_ctrl  = unit_sel_q[U_BRANCH] | unit_sel_q[U_JAL] | unit_sel_q[U_JALR];
    assign redirect = is_ctrl & alu_next_pc_valid;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        unit_sel_d  = unit_sel_q;
        unit_en_d   = '0;
        wait_cnt_d  = wait_cnt_q;
        next_pc_d   = next_pc_q;
        misalign_d  = misalign_q;
        imem_req_d  = 1'b0;
        rf_we_d     = 1'b0;
        rf_addr_d   = rf_addr_q;
        rf_data_d   = rf_data_q;
        illegal_d   = illegal_q;
        halted_d    = 1'b0;
        retired_d   = retired_q;

        case (state_q)
            ST_FETCH: begin
                // The request flop lags state by one cycle only after reset,
                // so a ready seen before the request is up is ignored.
                imem_req_d = 1'b1;
                if (imem_req_q && imem_ready) begin
                    instr_d    = imem_rdata;
                    imem_req_d = 1'b0;
                    state_d    = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec_sel == '0) begin
                    illegal_d = 1'b1;
                    halted_d  = 1'b1;
                    state_d   = ST_TRAP;
                end else begin
                    unit_sel_d = dec_sel;
                    unit_en_d  = dec_sel;
                    state_d    = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                wait_cnt_d = WAIT_LOAD;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                wait_cnt_d = wait_dec;
                if (wait_dec == 3'd0) begin
                    // ALU result is valid in this last WAIT cycle; capture
                    // everything writeback needs so the strobe is registered.
                    misalign_d = redirect & (alu_next_pc[1:0] != 2'b00);
                    next_pc_d  = redirect ? alu_next_pc : (pc_q + 32'd4);
                    rf_we_d    = ~misalign_d & ~unit_sel_q[U_BRANCH] & (alu_rd != 5'd0);
                    rf_addr_d  = alu_rd;
                    rf_data_d  = alu_rd_value;
                    state_d    = ST_WRITEBACK;
                end
            end
            ST_WRITEBACK: begin
                if (misalign_q) begin
                    illegal_d = 1'b1;
                    halted_d  = 1'b1;
                    state_d   = ST_TRAP;
                end else begin
                    pc_d       = next_pc_q;
                    retired_d  = retired_q + 32'd1;
                    imem_req_d = 1'b1;
                    state_d    = ST_FETCH;
                end
            end
            ST_TRAP: begin
                halted_d = 1'b1;
            end
            default: begin
                halted_d = 1'b1;
                state_d  = ST_TRAP;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            unit_sel_q <= '0;
            unit_en_q  <= '0;
            wait_cnt_q <= '0;
            next_pc_q  <= '0;
            misalign_q <= 1'b0;
            imem_req_q <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_addr_q  <= '0;
            rf_data_q  <= '0;
            illegal_q  <= 1'b0;
            halted_q   <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            unit_sel_q <= unit_sel_d;
            unit_en_q  <= unit_en_d;
            wait_cnt_q <= wait_cnt_d;
            next_pc_q  <= next_pc_d;
            misalign_q <= misalign_d;
            imem_req_q <= imem_req_d;
            rf_we_q    <= rf_we_d;
            rf_addr_q  <= rf_addr_d;
            rf_data_q  <= rf_data_d;
            illegal_q  <= illegal_d;
            halted_q   <= halted_d;
            retired_q  <= retired_d;
        end
    end

    assign imem_req            = imem_req_q;
    assign imem_addr           = pc_q;
    assign instruction         = instr_q;
    assign pc                  = pc_q;
    assign unit_enable         = unit_en_q;
    assign rf_write_enable     = rf_we_q;
    assign rf_write_addr       = rf_addr_q;
    assign rf_write_data       = rf_data_q;
    assign illegal_instruction = illegal_q;
    assign halted              = halted_q;
    assign retired_count       = retired_q;

endmodule

// File: tb/tb_rv_core_sequencer.sv
module tb_rv_core_sequencer;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;

    // main instance, EXEC_LATENCY = 1
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [6:0]  unit_enable;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_rd_value = '0;
    logic        alu_next_pc_valid = 1'b0;
    logic [31:0] alu_next_pc = '0;
    logic        rf_write_enable;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_write_data;
    logic        illegal_instruction;
    logic        halted;
    logic [31:0] retired_count;

    // second instance, EXEC_LATENCY = 3, reset PC at the top of memory
    logic        imem_req_l3;
    logic [31:0] imem_addr_l3;
    logic        imem_ready_l3 = 1'b1;
    logic [31:0] imem_rdata_l3 = 32'h0050_0093;
    logic [31:0] instruction_l3;
    logic [31:0] pc_l3;
    logic [6:0]  unit_enable_l3;
    logic [4:0]  alu_rd_l3 = 5'd3;
    logic [31:0] alu_rd_value_l3 = 32'd5;
    logic        alu_next_pc_valid_l3 = 1'b0;
    logic [31:0] alu_next_pc_l3 = '0;
    logic        rf_write_enable_l3;
    logic [4:0]  rf_write_addr_l3;
    logic [31:0] rf_write_data_l3;
    logic        illegal_instruction_l3;
    logic        halted_l3;
    logic [31:0] retired_count_l3;

    rv_core_sequencer #(.RESET_PC(32'h0000_0000), .EXEC_LATENCY(1)) dut (
        .clock(clock), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instruction(instruction), .pc(pc), .unit_enable(unit_enable),
        .alu_rd(alu_rd), .alu_rd_value(alu_rd_value),
        .alu_next_pc_valid(alu_next_pc_valid), .alu_next_pc(alu_next_pc),
        .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
        .rf_write_data(rf_write_data),
        .illegal_instruction(illegal_instruction), .halted(halted),
        .retired_count(retired_count)
    );

    rv_core_sequencer #(.RESET_PC(32'hFFFF_FFFC), .EXEC_LATENCY(3)) dut_l3 (
        .clock(clock), .reset_n(reset_n),
        .imem_req(imem_req_l3), .imem_addr(imem_addr_l3),
        .imem_ready(imem_ready_l3), .imem_rdata(imem_rdata_l3),
        .instruction(instruction_l3), .pc(pc_l3), .unit_enable(unit_enable_l3),
        .alu_rd(alu_rd_l3), .alu_rd_value(alu_rd_value_l3),
        .alu_next_pc_valid(alu_next_pc_valid_l3), .alu_next_pc(alu_next_pc_l3),
        .rf_write_enable(rf_write_enable_l3), .rf_write_addr(rf_write_addr_l3),
        .rf_write_data(rf_write_data_l3),
        .illegal_instruction(illegal_instruction_l3), .halted(halted_l3),
        .retired_count(retired_count_l3)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // scoreboard of expected register-file writes
    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t sb_q[$];
    wr_t mon_w;

    always @(negedge clock) begin
        if (reset_n && rf_write_enable) begin
            if (sb_q.size() == 0) begin
                check_val("rf_unexpected_write", {31'd0, rf_write_enable}, 32'd0);
            end else begin
                mon_w = sb_q.pop_front();
                check_val("rf_addr", {27'd0, rf_write_addr}, {27'd0, mon_w.addr});
                check_val("rf_data", rf_write_data, mon_w.data);
            end
        end
    end

    // latency and PC-wrap observation for the EXEC_LATENCY=3 instance
    logic armed_l3 = 1'b0;
    int   cnt_l3 = 0;
    int   lat_l3 = 0;
    logic lat_seen_l3 = 1'b0;
    logic wrap_seen = 1'b0;
    logic [31:0] wrap_pc = '0;

    always @(negedge clock) begin
        if (!reset_n) begin
            armed_l3 = 1'b0;
        end else begin
            if (unit_enable_l3 != '0) begin
                armed_l3 = 1'b1;
                cnt_l3   = 0;
            end else if (armed_l3) begin
                cnt_l3++;
                if (rf_write_enable_l3) begin
                    if (!lat_seen_l3) begin
                        lat_l3      = cnt_l3;
                        lat_seen_l3 = 1'b1;
                    end
                    armed_l3 = 1'b0;
                end
            end
            if (retired_count_l3 == 32'd1 && !wrap_seen) begin
                wrap_seen = 1'b1;
                wrap_pc   = pc_l3;
            end
        end
    end

    logic [31:0] pc_model = '0;
    logic [31:0] ret_model = '0;

    task automatic do_fetch(input logic [31:0] instr, input int delay);
        int n;
        logic [31:0] addr0;
        n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clock);
            n++;
        end
        check_val("fetch_req", {31'd0, imem_req}, 32'd1);
        check_val("fetch_addr", imem_addr, pc_model);
        addr0 = imem_addr;
        for (int i = 0; i < delay; i++) begin
            @(negedge clock);
            check_val("stall_req", {31'd0, imem_req}, 32'd1);
            check_val("stall_addr", imem_addr, addr0);
        end
        imem_ready = 1'b1;
        imem_rdata = instr;
        @(negedge clock);
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check_val("decode_req_low", {31'd0, imem_req}, 32'd0);
        check_val("instr_latched", instruction, instr);
    endtask

    task automatic exec_instr(input logic [31:0] instr, input int delay, input logic [6:0] exp_en,
                              input logic [4:0] rd, input logic [31:0] val,
                              input logic nv, input logic [31:0] npc);
        logic is_ctrl, redirect, mis, wr;
        logic [31:0] next_pc;
        wr_t w;
        alu_rd            = rd;
        alu_rd_value      = val;
        alu_next_pc_valid = nv;
        alu_next_pc       = npc;
        do_fetch(instr, delay);
        @(negedge clock);
        if (exp_en == '0) begin
            check_val("illegal_flag", {31'd0, illegal_instruction}, 32'd1);
            check_val("illegal_halted", {31'd0, halted}, 32'd1);
            for (int i = 0; i < 3; i++) begin
                check_val("trap_no_enable", {25'd0, unit_enable}, 32'd0);
                check_val("trap_no_req", {31'd0, imem_req}, 32'd0);
                @(negedge clock);
            end
            return;
        end
        check_val("unit_enable", {25'd0, unit_enable}, {25'd0, exp_en});
        is_ctrl  = exp_en[2] | exp_en[3] | exp_en[4];
        redirect = is_ctrl & nv;
        mis      = redirect & (npc[1:0] != 2'b00);
        wr       = !mis && !exp_en[2] && (rd != 5'd0);
        next_pc  = redirect ? npc : pc_model + 32'd4;
        if (wr) begin
            w.addr = rd;
            w.data = val;
            sb_q.push_back(w);
        end
        @(negedge clock);
        check_val("wait_enable_low", {25'd0, unit_enable}, 32'd0);
        @(negedge clock);
        check_val("wb_enable_low", {25'd0, unit_enable}, 32'd0);
        @(negedge clock);
        if (mis) begin
            check_val("misalign_halted", {31'd0, halted}, 32'd1);
            check_val("misalign_illegal", {31'd0, illegal_instruction}, 32'd1);
            check_val("misalign_pc", pc, pc_model);
            check_val("misalign_retired", retired_count, ret_model);
            @(negedge clock);
            check_val("misalign_no_req", {31'd0, imem_req}, 32'd0);
        end else begin
            pc_model  = next_pc;
            ret_model = ret_model + 32'd1;
            check_val("next_pc", pc, pc_model);
            check_val("retired", retired_count, ret_model);
            check_val("refetch_req", {31'd0, imem_req}, 32'd1);
        end
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n   = 1'b1;
        pc_model  = 32'h0;
        ret_model = 32'h0;
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clock);
        check_val("rst_pc", pc, 32'h0);
        check_val("rst_instr", instruction, 32'h0);
        check_val("rst_req", {31'd0, imem_req}, 32'd0);
        check_val("rst_enable", {25'd0, unit_enable}, 32'd0);
        check_val("rst_rf_we", {31'd0, rf_write_enable}, 32'd0);
        check_val("rst_illegal", {31'd0, illegal_instruction}, 32'd0);
        check_val("rst_halted", {31'd0, halted}, 32'd0);
        check_val("rst_retired", retired_count, 32'h0);
        check_val("rst_pc_l3", pc_l3, 32'hFFFF_FFFC);
        reset_n = 1'b1;
        #1;
        check_val("release_req_low", {31'd0, imem_req}, 32'd0);
        @(negedge clock);
        check_val("first_req", {31'd0, imem_req}, 32'd1);

        // instr, ready delay, expected enable, rd, value, redirect valid, target
        exec_instr(32'h0050_0093, 0,  7'b0000010, 5'd1, 32'd5,        1'b0, 32'h0);   // addi x1,x0,5
        exec_instr(32'h0020_80B3, 10, 7'b0000001, 5'd1, 32'd10,       1'b0, 32'h0);   // add
        exec_instr(32'h0000_0197, 0,  7'b1000000, 5'd3, 32'h8,        1'b0, 32'h0);   // auipc x3
        exec_instr(32'h1234_5037, 0,  7'b0100000, 5'd0, 32'h1234_5000, 1'b0, 32'h0);  // lui x0
        exec_instr(32'h0000_0063, 0,  7'b0000100, 5'd5, 32'h1,        1'b1, 32'h40);  // beq taken
        exec_instr(32'h0000_0063, 0,  7'b0000100, 5'd5, 32'h0,        1'b0, 32'h80);  // beq not taken
        exec_instr(32'h0080_00EF, 0,  7'b0001000, 5'd1, 32'h48,       1'b1, 32'h80);  // jal x1
        exec_instr(32'h0000_82E7, 0,  7'b0010000, 5'd5, 32'h84,       1'b1, 32'h100); // jalr x5

        // reset in the middle of WAIT aborts the instruction
        alu_rd = 5'd1; alu_rd_value = 32'd7; alu_next_pc_valid = 1'b0;
        do_fetch(32'h0070_0093, 0);
        @(negedge clock);
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check_val("abort_pc", pc, 32'h0);
        check_val("abort_retired", retired_count, 32'h0);
        check_val("abort_req", {31'd0, imem_req}, 32'd0);
        check_val("abort_rf_we", {31'd0, rf_write_enable}, 32'd0);
        check_val("abort_instr", instruction, 32'h0);
        do_reset();
        exec_instr(32'h0050_0093, 0, 7'b0000010, 5'd1, 32'd5, 1'b0, 32'h0);

        // misaligned jal target traps with pc held
        exec_instr(32'h0080_00EF, 0, 7'b0001000, 5'd1, 32'h8, 1'b1, 32'h42);

        // load opcode is illegal
        do_reset();
        exec_instr(32'h0000_2083, 0, 7'b0000000, 5'd1, 32'h0, 1'b0, 32'h0);

        check_val("l3_latency_seen", {31'd0, lat_seen_l3}, 32'd1);
        check_val("l3_wait_cycles", lat_l3 - 1, 32'd3);
        check_val("l3_wrap_seen", {31'd0, wrap_seen}, 32'd1);
        check_val("l3_wrap_pc", wrap_pc, 32'h0);
        check_val("sb_empty", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
